// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index; never below one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Start/done bus between a requester and the nibble-serial add/subtract unit.
// Handshake: start is honoured only on a rising edge where ready is high;
// result/cout/ovf/zero are valid in the cycle done is high and hold until the next accepted start.
interface nibble_serial_addsub_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport master (
        output start, op_sub, a, b,
        input  ready, busy, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, op_sub, a, b,
        output ready, busy, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/nibble_serial_addsub_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice reused for every nibble of the wide operation.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] f,
    output logic       c4
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a | b;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        f  = a ^ b ^ c[3:0];
        c4 = c[4];
    end
endmodule

// File: rtl/nibble_serial_addsub.sv
// W-bit add/subtract built by stepping one 4-bit CLA slice across the operands, LS nibble first.
module nibble_serial_addsub
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nibble_serial_addsub_if.slave  bus,
    output state_t                 dbg_state
);
    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       result_r;
    logic               cout_r;
    logic               ovf_r;
    logic               zero_r;
    logic               done_r;
    logic               busy_r;
    logic               ready_r;

    logic [NIBBLE_W-1:0] slice_f;
    logic                slice_c4;
    logic [W-1:0]        result_next;

    cla4_slice u_slice (
        .a  (a_r[NIBBLE_W-1:0]),
        .b  (b_r[NIBBLE_W-1:0]),
        .c0 (carry_r),
        .f  (slice_f),
        .c4 (slice_c4)
    );

    // Each slice output enters at the top so the LS nibble ends at bit 0 after NIBBLES steps.
    assign result_next = {slice_f, result_r[W-1:NIBBLE_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            idx      <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        // Subtract is A + ~B + 1, the +1 entering as the initial carry.
                        state    <= RUN;
                        a_r      <= bus.a;
                        b_r      <= bus.op_sub ? ~bus.b : bus.b;
                        carry_r  <= bus.op_sub;
                        idx      <= '0;
                        result_r <= '0;
                        cout_r   <= 1'b0;
                        ovf_r    <= 1'b0;
                        zero_r   <= 1'b0;
                        busy_r   <= 1'b1;
                        ready_r  <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result_r <= result_next;
                    a_r      <= a_r >> NIBBLE_W;
                    b_r      <= b_r >> NIBBLE_W;
                    carry_r  <= slice_c4;
                    idx      <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        // Signed overflow: like-signed inputs giving an opposite-signed sum.
                        cout_r  <= slice_c4;
                        ovf_r   <= (a_r[NIBBLE_W-1] == b_r[NIBBLE_W-1]) &&
                                   (slice_f[NIBBLE_W-1] != a_r[NIBBLE_W-1]);
                        zero_r  <= (result_next == '0);
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready  = ready_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.cout   = cout_r;
    assign bus.ovf    = ovf_r;
    assign bus.zero   = zero_r;
    assign dbg_state  = state;

endmodule
